dac_segment_encoder: RTL

- Digital front end that directly feeds driver_cell.
- Splits a 12-bit DAC sample code into a 7-bit binary LSB field and a 17-element thermometer MSB field, with registered true and complement outputs.
- Applies data-weighted-averaging (DWA) rotation to the thermometer elements to spread unit-cell mismatch.
- Sequences the driver power-down control (pdb) through an OFF/SETTLE/ON state machine so the driver never sees data while unpowered.

---
 rtl/dac_pkg.sv | 32 +++
 rtl/dac_segment_encoder_if.sv | 28 ++
 rtl/dac_segment_encoder_dwa_rotator.sv | 39 +++
 rtl/dac_segment_encoder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, power-state enum and thermometer rotation helper for the
// DAC segment encoder.
package dac_pkg;

  localparam int BIN_W         = 7;
  localparam int THERM_N       = 17;
  localparam int MSB_W         = 5;
  localparam int CODE_W        = 12;
  localparam int SETTLE_CYCLES = 16;
  localparam int PTR_W         = 5;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    OFF,
    SETTLE,
    ON
  } pwr_state_t;

  // n consecutive ones starting at bit ptr, wrapping modulo THERM_N.
  function automatic logic [THERM_N-1:0] therm_rotate(input logic [MSB_W-1:0] n,
                                                      input logic [PTR_W-1:0] ptr);
    logic [THERM_N-1:0]   mask;
    logic [2*THERM_N-1:0] dbl;
    mask = '0;
    for (int i = 0; i < THERM_N; i++) begin
      if (i < int'(n)) mask[i] = 1'b1;
    end
    dbl = {mask, mask} << ptr;
    return dbl[2*THERM_N-1:THERM_N];
  endfunction

endpackage

// File: rtl/dac_segment_encoder_if.sv
// Sample, control and driver-cell signals of the DAC segment encoder.
interface dac_segment_encoder_if;
  import dac_pkg::*;

  logic [CODE_W-1:0]  code_in;
  logic               code_valid;
  logic               pdb_req;
  logic               dem_en;
  logic               ovf_clr;
  logic [BIN_W-1:0]   datain;
  logic [BIN_W-1:0]   datainb;
  logic [THERM_N-1:0] datatherm;
  logic [THERM_N-1:0] datathermb;
  logic               pdb;
  logic               out_valid;
  logic               ovf;

  modport master (
    output code_in, code_valid, pdb_req, dem_en, ovf_clr,
    input  datain, datainb, datatherm, datathermb, pdb, out_valid, ovf
  );

  modport slave (
    input  code_in, code_valid, pdb_req, dem_en, ovf_clr,
    output datain, datainb, datatherm, datathermb, pdb, out_valid, ovf
  );

endinterface

// File: rtl/dac_segment_encoder_dwa_rotator.sv
// Data-weighted-averaging pointer: holds the next free unit element and
// produces the rotated thermometer mask for the current sample.
module dwa_rotator
  import dac_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  input  logic               dem_en,
  input  logic [MSB_W-1:0]   n,
  output logic [THERM_N-1:0] pattern
);

  localparam logic [PTR_W:0] WRAP = (PTR_W+1)'(THERM_N);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;

  // With rotation disabled the pointer parks at element 0.
  always_comb begin
    sum   = {1'b0, ptr_q} + {1'b0, n};
    ptr_d = ptr_q;
    if (clear || !dem_en) begin
      ptr_d = '0;
    end else if (advance) begin
      if (sum >= WRAP) ptr_d = PTR_W'(sum - WRAP);
      else             ptr_d = sum[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign pattern = therm_rotate(n, dem_en ? ptr_q : '0);

endmodule

// File: rtl/dac_segment_encoder.sv
// Segmenting front end for driver_cell: clamp, two-stage pipeline with DWA
// thermometer rotation, complement outputs and pdb power sequencing.
module dac_segment_encoder
  import dac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dac_segment_encoder_if.slave  bus
);

  pwr_state_t         state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic [BIN_W-1:0]   s1_lsb_q, s1_lsb_d;
  logic [MSB_W-1:0]   s1_n_q, s1_n_d;
  logic               ovf_q, ovf_d;
  logic [BIN_W-1:0]   datain_q, datain_d;
  logic [BIN_W-1:0]   datainb_q, datainb_d;
  logic [THERM_N-1:0] datatherm_q, datatherm_d;
  logic [THERM_N-1:0] datathermb_q, datathermb_d;
  logic               pdb_q, pdb_d;
  logic               out_valid_q, out_valid_d;

  logic [MSB_W-1:0]   msb;
  logic [BIN_W-1:0]   lsb;
  logic               clamp;
  logic               run;
  logic               accept;
  logic [THERM_N-1:0] rot_pattern;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      OFF: begin
        settle_cnt_d = '0;
        if (bus.pdb_req) state_d = SETTLE;
      end
      SETTLE: begin
        if (!bus.pdb_req) begin
          state_d      = OFF;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d      = ON;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      ON: begin
        if (!bus.pdb_req) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  // Data only moves while ON and staying ON; a power-down edge flushes the pipe.
  assign run    = (state_q == ON) && (state_d == ON);
  assign accept = run && bus.code_valid;
  assign msb    = bus.code_in[CODE_W-1:BIN_W];
  assign lsb    = bus.code_in[BIN_W-1:0];
  assign clamp  = msb > MSB_W'(THERM_N);

  always_comb begin
    s1_valid_d = accept;
    s1_n_d     = s1_n_q;
    s1_lsb_d   = s1_lsb_q;
    if (accept) begin
      s1_n_d   = clamp ? MSB_W'(THERM_N) : msb;
      s1_lsb_d = clamp ? '1 : lsb;
    end
    ovf_d = (accept && clamp) || (ovf_q && !bus.ovf_clr);
  end

  dwa_rotator u_dwa (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_d != ON),
    .advance (run && s1_valid_q),
    .dem_en  (bus.dem_en),
    .n       (s1_n_q),
    .pattern (rot_pattern)
  );

  // Outside steady ON the driver sees the zero code; otherwise hold until a new sample.
  always_comb begin
    datain_d    = datain_q;
    datatherm_d = datatherm_q;
    out_valid_d = 1'b0;
    if (!run) begin
      datain_d    = '0;
      datatherm_d = '0;
    end else if (s1_valid_q) begin
      datain_d    = s1_lsb_q;
      datatherm_d = rot_pattern;
      out_valid_d = 1'b1;
    end
    datainb_d    = ~datain_d;
    datathermb_d = ~datatherm_d;
    pdb_d        = (state_d != OFF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OFF;
      settle_cnt_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_lsb_q     <= '0;
      s1_n_q       <= '0;
      ovf_q        <= 1'b0;
      datain_q     <= '0;
      datainb_q    <= '1;
      datatherm_q  <= '0;
      datathermb_q <= '1;
      pdb_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_lsb_q     <= s1_lsb_d;
      s1_n_q       <= s1_n_d;
      ovf_q        <= ovf_d;
      datain_q     <= datain_d;
      datainb_q    <= datainb_d;
      datatherm_q  <= datatherm_d;
      datathermb_q <= datathermb_d;
      pdb_q        <= pdb_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.datain     = datain_q;
  assign bus.datainb    = datainb_q;
  assign bus.datatherm  = datatherm_q;
  assign bus.datathermb = datathermb_q;
  assign bus.pdb        = pdb_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ovf        = ovf_q;

endmodule
